// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing defaults, derived totals and the
// lock/run state encoding used by the timing generator.
package vga_pkg;

    localparam int CLK_DIV_DEF   = 8;
    localparam int LOCK_WAIT_DEF = 1024;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF =
        H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF =
        V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_lock_qual.sv
// PLL lock synchroniser plus consecutive-high qualification counter;
// lock_ok rises once the synchronised lock has been high LOCK_WAIT cycles.
module vga_lock_qual
    import vga_pkg::*;
#(
    parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic locked,
    output logic lock_ok
);

    localparam int CW = cnt_width(LOCK_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at LOCK_WAIT-1; any low sample restarts from zero.
    always_comb begin
        cnt_d = '0;
        if (sync_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= locked;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_ok = sync_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel divider, x/y raster counters and
// registered sync/active/frame strobes, gated by PLL lock.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int LOCK_WAIT = LOCK_WAIT_DEF,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = cnt_width(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);

    logic lock_ok;

    vga_state_e    state_q;
    vga_state_e    state_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [9:0]    x_q;
    logic [9:0]    x_d;
    logic [9:0]    y_q;
    logic [9:0]    y_d;

    logic pix_q;
    logic pix_d;
    logic hs_q;
    logic hs_d;
    logic vs_q;
    logic vs_d;
    logic act_q;
    logic act_d;
    logic fs_q;
    logic fs_d;
    logic run_d;

    vga_lock_qual #(
        .LOCK_WAIT(LOCK_WAIT)
    ) u_lock_qual (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .locked  (locked),
        .lock_ok (lock_ok)
    );

    // Counters only advance while staying in RUN; entry and exit clear them.
    always_comb begin
        state_d = lock_ok ? RUN : WAIT_LOCK;
        div_d   = '0;
        x_d     = '0;
        y_d     = '0;
        if (state_q == RUN && state_d == RUN) begin
            div_d = div_q + DW'(1);
            x_d   = x_q;
            y_d   = y_q;
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
        end
    end

    // Strobes are decoded from next-state so they register alongside it.
    always_comb begin
        run_d = (state_d == RUN);
        pix_d = run_d && (div_d == DIV_LAST);
        hs_d  = !(run_d && x_d >= HS_START && x_d <= HS_END);
        vs_d  = !(run_d && y_d >= VS_START && y_d <= VS_END);
        act_d = run_d && (x_d < X_VIS) && (y_d < Y_VIS);
        fs_d  = pix_d && (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            act_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            act_q   <= act_d;
            fs_q    <= fs_d;
        end
    end

    assign pix_en      = pix_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

endmodule
